dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter_starve_counter.sv | 23 ++
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter shared types.
// Owner-state encoding and default bus widths.
package dmem_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    NIC_RD = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter bus bundle.
// Pipeline, NIC and dmem sides in one interface.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  cpu_req;
  logic                  cpu_wr;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_stall;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  nic_req;
  logic                  nic_wr;
  logic [ADDR_WIDTH-1:0] nic_addr;
  logic [DATA_WIDTH-1:0] nic_wdata;
  logic                  nic_gnt;
  logic                  nic_rvalid;
  logic [DATA_WIDTH-1:0] nic_rdata;

  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  nic_req, nic_wr, nic_addr, nic_wdata,
    output nic_gnt, nic_rvalid, nic_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output nic_req, nic_wr, nic_addr, nic_wdata,
    input  nic_gnt, nic_rvalid, nic_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// NIC starvation counter.
// Saturating up-counter with synchronous clear.
module starve_counter #(
  parameter int LIMIT = 4,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // count denied cycles, hold at LIMIT
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != W'(LIMIT))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter top.
// Shares one dmem port between pipeline and NIC.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]         starve;
  logic                  forced;
  logic                  cpu_gnt;
  logic                  nic_gnt;
  logic                  starve_inc;
  owner_e                state;
  owner_e                state_nx;
  logic                  wr_mux;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;

  // grant: CPU first unless NIC has starved
  always_comb begin
    forced  = bus.nic_req &&
              (starve == CW'(STARVE_LIMIT));
    cpu_gnt = !rst && bus.cpu_req && !forced;
    nic_gnt = !rst && bus.nic_req &&
              (forced || !bus.cpu_req);
  end

  assign starve_inc = bus.nic_req && !nic_gnt;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc   (starve_inc),
    .clr   (!starve_inc),
    .count (starve)
  );

  // steer the winner onto the dmem port
  always_comb begin
    wr_mux    = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    unique case (1'b1)
      cpu_gnt: begin
        wr_mux    = bus.cpu_wr;
        addr_mux  = bus.cpu_addr;
        wdata_mux = bus.cpu_wdata;
      end
      nic_gnt: begin
        wr_mux    = bus.nic_wr;
        addr_mux  = bus.nic_addr;
        wdata_mux = bus.nic_wdata;
      end
      default: ;
    endcase
  end

  // owner state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // remember who owns next cycle's read data
  always_comb begin
    state_nx = IDLE;
    if (cpu_gnt && !bus.cpu_wr) begin
      state_nx = CPU_RD;
    end else if (nic_gnt && !bus.nic_wr) begin
      state_nx = NIC_RD;
    end
  end

  assign bus.mem_en     = cpu_gnt || nic_gnt;
  assign bus.mem_wr     = wr_mux;
  assign bus.mem_addr   = addr_mux;
  assign bus.mem_wdata  = wdata_mux;
  assign bus.cpu_stall  = !rst && bus.cpu_req && !cpu_gnt;
  assign bus.nic_gnt    = nic_gnt;
  assign bus.cpu_rvalid = !rst && (state == CPU_RD);
  assign bus.nic_rvalid = !rst && (state == NIC_RD);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.nic_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// dmem_arbiter testbench.
// Random and directed traffic against a reference model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DW  = 64;
  localparam int AW  = 16;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_arbiter_if #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) bus ();

  dmem_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // dmem: one-cycle read latency, garbage when not read
  logic [DW-1:0] mem [logic [AW-1:0]];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wr) begin
      mem[bus.mem_addr] = bus.mem_wdata;
    end
    if (bus.mem_en && !bus.mem_wr) begin
      bus.mem_rdata <= mem.exists(bus.mem_addr) ?
                       mem[bus.mem_addr] : '0;
    end else begin
      bus.mem_rdata <= {$urandom, $urandom};
    end
  end

  // reference model state
  int            n_tests;
  int            n_fail;
  int            starve;
  logic          pend_c;
  logic          pend_n;
  logic [DW-1:0] pend_d;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic          last_cg;
  logic          dut_ng;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(
    input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // one cycle: drive, check at negedge, advance model
  task automatic step(
    input logic r,
    input logic cr, input logic cw,
    input logic [AW-1:0] ca, input logic [DW-1:0] cd,
    input logic nr, input logic nw,
    input logic [AW-1:0] na, input logic [DW-1:0] nd);
    logic          frc, cg, ng, ew, busy;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    rst           = r;
    bus.cpu_req   = cr;
    bus.cpu_wr    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.nic_req   = nr;
    bus.nic_wr    = nw;
    bus.nic_addr  = na;
    bus.nic_wdata = nd;
    @(negedge clk);
    frc  = nr && (starve == LIM);
    cg   = !r && cr && !frc;
    ng   = !r && nr && !cg;
    busy = cg || ng;
    ea   = cg ? ca : (ng ? na : '0);
    ed   = cg ? cd : (ng ? nd : '0);
    ew   = cg ? cw : nw;
    chk("cpu_stall", bus.cpu_stall, !r && cr && !cg);
    chk("nic_gnt", bus.nic_gnt, ng);
    chk("mem_en", bus.mem_en, busy);
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_wdata", bus.mem_wdata, ed);
    if (busy) chk("mem_wr", bus.mem_wr, ew);
    chk("cpu_rvalid", bus.cpu_rvalid, pend_c && !r);
    chk("nic_rvalid", bus.nic_rvalid, pend_n && !r);
    if (pend_c && !r) chk("cpu_rdata", bus.cpu_rdata, pend_d);
    if (pend_n && !r) chk("nic_rdata", bus.nic_rdata, pend_d);
    dut_ng = bus.nic_gnt;
    if (cg && cw) ref_mem[ca] = cd;
    if (ng && nw) ref_mem[na] = nd;
    pend_c = cg && !cw;
    pend_n = ng && !nw;
    pend_d = cg ? ref_rd(ca) : ref_rd(na);
    if (r || ng || !nr) starve = 0;
    else if (starve < LIM) starve++;
    last_cg = cg;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom_range(0, 15)) * 16'h1111;
  endfunction

  initial begin
    logic          cr, cw, nr, nw, r;
    logic [AW-1:0] ca, na;
    logic [DW-1:0] cd, nd;
    int            k;
    n_tests = 0;
    n_fail  = 0;
    starve  = 0;
    pend_c  = 1'b0;
    pend_n  = 1'b0;
    pend_d  = '0;
    last_cg = 1'b0;
    dut_ng  = 1'b0;
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.nic_req   = 1'b0;
    bus.nic_wr    = 1'b0;
    bus.nic_addr  = '0;
    bus.nic_wdata = '0;
    @(posedge clk);
    #1;

    // reset holds outputs quiet despite requests
    step(1, 1, 0, 16'h0010, '0, 1, 0, 16'h0020, '0);
    step(1, 1, 1, 16'h0011, '1, 1, 1, 16'h0021, '1);

    // CPU write then read back at 0x0010
    step(0, 1, 1, 16'h0010, 64'h1234_5678_9abc_def0,
         0, 0, '0, '0);
    step(0, 1, 0, 16'h0010, '0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0);

    // NIC starved by a held CPU: granted on 5th try
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0, 16'h0010, '0, 1, 0, 16'h0020, '0);
      if (dut_ng) begin
        k = i;
        break;
      end
    end
    chk("starve_cycles", k, 5);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0);

    // lone NIC write, no response afterwards
    step(0, 0, 0, '0, '0, 1, 1, 16'h0020, 64'hDEADBEEF);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0);

    // CPU read then NIC read back to back
    step(0, 1, 0, 16'h0010, '0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 1, 0, 16'h0020, '0);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0);

    // reset right after a granted NIC read
    step(0, 0, 0, '0, '0, 1, 0, 16'h0020, '0);
    step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0);

    // NIC drops after 3 denials; counter restarts
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 16'h0030, '0, 1, 0, 16'h0040, '0);
    step(0, 1, 0, 16'h0030, '0, 0, 0, '0, '0);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0, 16'h0030, '0, 1, 0, 16'h0040, '0);
      if (dut_ng) begin
        k = i;
        break;
      end
    end
    chk("restart_cycles", k, 5);

    // random traffic; requesters hold while denied
    cr = 0; cw = 0; ca = '0; cd = '0;
    nr = 0; nw = 0; na = '0; nd = '0;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 59) == 0);
      step(r, cr, cw, ca, cd, nr, nw, na, nd);
      if (!(cr && !last_cg) || r) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = $urandom_range(0, 1) == 1;
        ca = rnd_addr();
        cd = {$urandom, $urandom};
      end
      if (!(nr && !dut_ng) || r ||
          $urandom_range(0, 9) == 0) begin
        nr = ($urandom_range(0, 2) != 0);
        nw = $urandom_range(0, 1) == 1;
        na = rnd_addr();
        nd = {$urandom, $urandom};
      end
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
